dot_product_sequencer: RTL and testbench

Controller that sequences the `dotProduct_lut` datapath. It accepts one dot-product job as parallel vectors over a valid/ready handshake, pulses `Start`, and serialises both vectors onto `SerialData`. It then waits for `Done`, captures `DataOut`, and presents the result over a second valid/ready handshake. It sits between the job source (CPU/test harness) and the `dotProduct_lut` unit, replacing the ad-hoc stimulus driver.

---
 rtl/dot_product_pkg.sv | 25 ++
 rtl/dp_piso.sv | 30 +++
 rtl/dot_product_sequencer.sv | 139 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared constants, state encoding and sizing helper for the dot-product sequencer.
package dot_product_pkg;

  localparam int NUM_ELEM    = 4;
  localparam int ELEM_W      = 8;
  localparam int OUT_W       = 19;
  localparam int STREAM_LEN  = 2 * NUM_ELEM * ELEM_W;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    HOLD
  } state_t;

  // Counter width wide enough for whichever of the two phases is longer.
  function automatic int cnt_width(input int stream_len, input int timeout);
    return $clog2((stream_len > timeout) ? stream_len : timeout);
  endfunction

  localparam int CNT_W = cnt_width(STREAM_LEN, TIMEOUT_DEF);

endpackage

// File: rtl/dp_piso.sv
// Parallel-load, right-shifting register; bit 0 is the serial output.
module dp_piso
  import dot_product_pkg::*;
#(
  parameter int WIDTH = STREAM_LEN
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg;

  // Load wins over shift; zeros fill in from the top as bits leave at the bottom.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign sout = shreg[0];

endmodule

// File: rtl/dot_product_sequencer.sv
// Accepts a dot-product job, streams both vectors to the datapath, and
// returns the datapath result (or a timeout) over a valid/ready handshake.
module dot_product_sequencer #(
  parameter int NUM_ELEM = dot_product_pkg::NUM_ELEM,
  parameter int ELEM_W   = dot_product_pkg::ELEM_W,
  parameter int OUT_W    = dot_product_pkg::OUT_W,
  parameter int TIMEOUT  = dot_product_pkg::TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ELEM*ELEM_W-1:0] in_x,
  input  logic [NUM_ELEM*ELEM_W-1:0] in_y,
  output logic                       Start,
  output logic                       SerialData,
  input  logic [OUT_W-1:0]           DataOut,
  input  logic                       Done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_data,
  output logic                       res_timeout,
  output logic                       busy
);

  import dot_product_pkg::*;

  localparam int VEC_W       = NUM_ELEM * ELEM_W;
  localparam int STREAM_BITS = 2 * VEC_W;
  localparam int CW          = cnt_width(STREAM_BITS, TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(STREAM_BITS - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   bit_cnt;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            last_bit;
  logic            timed_out;
  logic            sout;
  logic            start_d;
  logic            serial_d;
  logic            valid_d;
  logic            busy_d;
  logic            timeout_d;
  logic [OUT_W-1:0] data_d;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && (state == IDLE);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign timed_out = (wait_cnt == LAST_WAIT);

  dp_piso #(
    .WIDTH(STREAM_BITS)
  ) u_piso (
    .clk  (clk),
    .Reset(Reset),
    .load (accept),
    .shift(next_state == SHIFT),
    .din  ({in_y, in_x}),
    .sout (sout)
  );

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; Done only matters while waiting, and beats the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = START;
      START:   next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = WAIT;
      WAIT:    if (Done || timed_out) next_state = HOLD;
      HOLD:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit and wait counters, both cleared when a job is accepted.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else if (accept) begin
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == SHIFT) bit_cnt <= bit_cnt + 1'b1;
      if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    start_d   = (next_state == START);
    serial_d  = (next_state == SHIFT) ? sout : 1'b0;
    valid_d   = (next_state == HOLD);
    busy_d    = (next_state != IDLE);
    data_d    = res_data;
    timeout_d = res_timeout;
    if (state == WAIT) begin
      if (Done) begin
        data_d    = DataOut;
        timeout_d = 1'b0;
      end else if (timed_out) begin
        data_d    = '0;
        timeout_d = 1'b1;
      end
    end
  end

  // Registered outputs; the result stays put through HOLD until the next capture.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      Start       <= 1'b0;
      SerialData  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      Start       <= start_d;
      SerialData  <= serial_d;
      res_valid   <= valid_d;
      res_data    <= data_d;
      res_timeout <= timeout_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: plays the datapath, models the expected
// cycle schedule per job, and pins the model with hand-computed results.
module tb_dot_product_sequencer;

  localparam int NE = 4;
  localparam int EW = 8;
  localparam int OW = 19;
  localparam int TO = 16;
  localparam int VW = NE * EW;
  localparam int SL = 2 * VW;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_x = '0;
  logic [VW-1:0] in_y = '0;
  logic          Start;
  logic          SerialData;
  logic [OW-1:0] DataOut = '0;
  logic          Done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_data;
  logic          res_timeout;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  dot_product_sequencer #(
    .NUM_ELEM(NE),
    .ELEM_W  (EW),
    .OUT_W   (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .Start      (Start),
    .SerialData (SerialData),
    .DataOut    (DataOut),
    .Done       (Done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_timeout(res_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference dot product of the de-serialised stream (x then y, LSB first).
  function automatic logic [OW-1:0] dp_model(input logic [SL-1:0] s);
    int acc;
    acc = 0;
    for (int i = 0; i < NE; i++) begin
      acc += int'($signed(s[i*EW +: EW])) * int'($signed(s[VW + i*EW +: EW]));
    end
    return OW'(acc);
  endfunction

  // Job-level expectation: cycles since handshake, plus the pending result.
  int            m_cyc = -1;
  bit            m_hold = 1'b0;
  bit            m_idle;
  logic [SL-1:0] m_stream = '0;
  logic [OW-1:0] m_data = '0;
  logic          m_to = 1'b0;
  logic          m_serial;

  // Compare DUT against the expectation mid-cycle, then advance using this cycle's inputs.
  always @(negedge clk) begin
    if (!Reset) begin
      m_cyc  = -1;
      m_hold = 1'b0;
      m_data = '0;
      m_to   = 1'b0;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_start", 32'(Start), 32'd0);
      checkOutput("rst_serial", 32'(SerialData), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_data", 32'(res_data), 32'd0);
      checkOutput("rst_res_timeout", 32'(res_timeout), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end else begin
      m_idle   = (m_cyc < 0) && !m_hold;
      m_serial = (m_cyc >= 2 && m_cyc <= SL + 1) ? m_stream[m_cyc-2] : 1'b0;
      checkOutput("in_ready", 32'(in_ready), 32'(m_idle));
      checkOutput("start", 32'(Start), 32'(m_cyc == 1));
      checkOutput("serial", 32'(SerialData), 32'(m_serial));
      checkOutput("busy", 32'(busy), 32'(!m_idle));
      checkOutput("res_valid", 32'(res_valid), 32'(m_hold));
      if (m_hold) begin
        checkOutput("res_data", 32'(res_data), 32'(m_data));
        checkOutput("res_timeout", 32'(res_timeout), 32'(m_to));
      end
      if (m_idle) begin
        if (in_valid) begin
          m_stream = {in_y, in_x};
          m_cyc    = 1;
        end
      end else if (m_hold) begin
        if (res_ready) m_hold = 1'b0;
      end else if (m_cyc >= SL + 2 && Done) begin
        m_data = DataOut;
        m_to   = 1'b0;
        m_hold = 1'b1;
        m_cyc  = -1;
      end else if (m_cyc >= SL + 2 && (m_cyc - (SL + 2)) == TO - 1) begin
        m_data = '0;
        m_to   = 1'b1;
        m_hold = 1'b1;
        m_cyc  = -1;
      end else begin
        m_cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full job: handshake, act as datapath, wait for result, then take it.
  task automatic applyStimulus(
    input  logic [VW-1:0] x,
    input  logic [VW-1:0] y,
    input  int            done_off,
    input  bit            spurious,
    input  int            hold_cycles,
    input  bit            offer,
    output logic [OW-1:0] r_data,
    output logic          r_to,
    output int            lat,
    output int            start_cnt,
    output int            start_cyc,
    output logic [SL-1:0] bits
  );
    int            cyc;
    int            n;
    logic [OW-1:0] dp;
    start_cnt = 0;
    start_cyc = -1;
    bits      = '0;
    in_x      = x;
    in_y      = y;
    in_valid  = 1'b1;
    step();
    cyc      = 1;
    in_valid = 1'b0;
    in_x     = VW'($urandom);
    in_y     = VW'($urandom);
    for (int c = 1; c <= SL + 1; c++) begin
      if (Start) begin
        start_cnt++;
        start_cyc = c;
      end
      if (c >= 2) bits[c-2] = SerialData;
      if (spurious && c == 10) begin
        Done    = 1'b1;
        DataOut = 19'h5a5a5;
      end
      step();
      cyc++;
      Done = 1'b0;
    end
    dp = dp_model(bits);
    if (done_off >= 0) begin
      for (int k = 0; k < done_off; k++) begin
        step();
        cyc++;
      end
      Done    = 1'b1;
      DataOut = dp;
      step();
      cyc++;
      Done    = 1'b0;
      DataOut = OW'($urandom);
    end
    n = 0;
    while (!res_valid && n < TO + 8) begin
      step();
      cyc++;
      n++;
    end
    checkOutput("result_arrives", 32'(res_valid), 32'd1);
    lat      = cyc;
    r_data   = res_data;
    r_to     = res_timeout;
    in_valid = offer;
    for (int h = 0; h < hold_cycles; h++) begin
      if (offer && h == 3) begin
        Done    = 1'b1;
        DataOut = 19'h1234;
      end
      step();
      Done = 1'b0;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // Bound the whole run in case the DUT wedges somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [VW-1:0] x123, y567, xneg, ymax;
  logic [OW-1:0] r_data;
  logic          r_to;
  int            lat, s_cnt, s_cyc;
  logic [SL-1:0] bits;

  initial begin
    x123 = {8'd4, 8'd3, 8'd2, 8'd1};
    y567 = {8'd8, 8'd7, 8'd6, 8'd5};
    xneg = {4{8'h80}};
    ymax = {4{8'h7f}};

    #2 Reset = 1'b0;
    #1;
    checkOutput("por_in_ready", 32'(in_ready), 32'd1);
    checkOutput("por_busy", 32'(busy), 32'd0);
    checkOutput("por_start", 32'(Start), 32'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1'b1;
    step();

    $display("[TB] stream order and basic result");
    applyStimulus(x123, y567, 0, 1'b0, 0, 1'b0, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("start_count", 32'(s_cnt), 32'd1);
    checkOutput("start_cycle", 32'(s_cyc), 32'd1);
    checkOutput("x0_bits", 32'(bits[7:0]), 32'h01);
    checkOutput("y3_bits", 32'(bits[63:56]), 32'h08);
    checkOutput("basic_data", 32'(r_data), 32'd70);
    checkOutput("basic_timeout", 32'(r_to), 32'd0);
    checkOutput("basic_latency", 32'(lat), 32'd67);

    $display("[TB] negative extreme with Done pulsed during shift");
    applyStimulus(xneg, xneg, 3, 1'b1, 0, 1'b0, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("negneg_data", 32'(r_data), 32'h10000);
    checkOutput("negneg_timeout", 32'(r_to), 32'd0);
    checkOutput("negneg_latency", 32'(lat), 32'd70);

    $display("[TB] mixed extreme with back-pressure");
    applyStimulus(xneg, ymax, 5, 1'b0, 20, 1'b1, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("negpos_data", 32'(r_data), 32'h70200);
    checkOutput("negpos_timeout", 32'(r_to), 32'd0);
    checkOutput("negpos_latency", 32'(lat), 32'd72);

    $display("[TB] timeout");
    applyStimulus(y567, x123, -1, 1'b0, 2, 1'b0, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("timeout_flag", 32'(r_to), 32'd1);
    checkOutput("timeout_data", 32'(r_data), 32'd0);
    checkOutput("timeout_latency", 32'(lat), 32'(SL + 2 + TO));

    $display("[TB] Done on the timeout cycle");
    applyStimulus(x123, y567, TO - 1, 1'b0, 1, 1'b0, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("tie_timeout", 32'(r_to), 32'd0);
    checkOutput("tie_data", 32'(r_data), 32'd70);
    checkOutput("tie_latency", 32'(lat), 32'(SL + 2 + TO));

    $display("[TB] reset in the middle of shifting");
    in_x     = x123;
    in_y     = y567;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_start", 32'(Start), 32'd0);
    checkOutput("abort_serial", 32'(SerialData), 32'd0);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_res_data", 32'(res_data), 32'd0);
    checkOutput("abort_res_timeout", 32'(res_timeout), 32'd0);
    step();
    step();
    Reset = 1'b1;
    step();

    $display("[TB] job after reset");
    applyStimulus(x123, y567, 2, 1'b0, 0, 1'b0, r_data, r_to, lat, s_cnt, s_cyc, bits);
    checkOutput("post_reset_data", 32'(r_data), 32'd70);
    checkOutput("post_reset_timeout", 32'(r_to), 32'd0);
    checkOutput("post_reset_latency", 32'(lat), 32'd69);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
